// File: rtl/effect_pkg.sv
// Shared encodings for the effect scheduler: FSM states, SEL codes and STEP width.
package effect_pkg;

    localparam int STEP_W = 6;

    typedef logic [1:0] state_t;

    // State codes equal the SEL codes so SEL is read straight off the state register.
    localparam state_t IDLE    = 2'd0;
    localparam state_t PH_HEX  = 2'd1;
    localparam state_t PH_LEDG = 2'd2;
    localparam state_t PH_LEDR = 2'd3;

    localparam logic [1:0] SEL_NONE = 2'd0;
    localparam logic [1:0] SEL_HEX  = 2'd1;
    localparam logic [1:0] SEL_LEDG = 2'd2;
    localparam logic [1:0] SEL_LEDR = 2'd3;

endpackage

// File: rtl/tick_gen.sv
// Prescaler: counts 0..TICK_DIV-1 while enabled and pulses TICK on the last count.
module tick_gen #(
    parameter int unsigned TICK_DIV = 5000000
) (
    input  logic CK,
    input  logic RS,
    input  logic EN,
    output logic TICK
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count_q;

    // Freezing when disabled keeps the count at 0 in IDLE, since IDLE is only entered on a wrap.
    always_ff @(posedge CK) begin
        if (RS) begin
            count_q <= '0;
        end else if (EN) begin
            count_q <= (count_q == LAST) ? '0 : count_q + 1'b1;
        end
    end

    assign TICK = EN && (count_q == LAST);

endmodule

// File: rtl/effect_scheduler.sv
// Sequences the HEX -> LEDG -> LEDR effect phases on a slow tick and counts completed rounds.
module effect_scheduler
    import effect_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 5000000,
    parameter int unsigned HEX_TICKS  = 20,
    parameter int unsigned LEDG_TICKS = 32,
    parameter int unsigned LEDR_TICKS = 16
) (
    input  logic              CK,
    input  logic              RS,
    input  logic              RUN,
    input  logic              HOLD,
    output logic [1:0]        SEL,
    output logic [STEP_W-1:0] STEP,
    output logic              TICK,
    output logic              DONE,
    output logic [7:0]        ROUNDS
);

    state_t            state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [7:0]        rounds_q, rounds_d;
    logic [STEP_W-1:0] last_step;
    logic              tick_en;
    logic              tick;
    logic              done;

    assign tick_en = !HOLD && (state_q != IDLE);

    tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_gen (
        .CK  (CK),
        .RS  (RS),
        .EN  (tick_en),
        .TICK(tick)
    );

    always_comb begin
        last_step = '0;
        unique case (state_q)
            PH_HEX:  last_step = STEP_W'(HEX_TICKS - 1);
            PH_LEDG: last_step = STEP_W'(LEDG_TICKS - 1);
            PH_LEDR: last_step = STEP_W'(LEDR_TICKS - 1);
            default: last_step = '0;
        endcase
    end

    assign done = tick && (step_q == last_step);

    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        rounds_d = rounds_q;
        if (state_q == IDLE) begin
            if (RUN && !HOLD) begin
                state_d = PH_HEX;
                step_d  = '0;
            end
        end else if (done) begin
            step_d = '0;
            unique case (state_q)
                PH_HEX:  state_d = PH_LEDG;
                PH_LEDG: state_d = PH_LEDR;
                PH_LEDR: begin
                    // RUN is only consulted here, so dropping it never cuts a round short.
                    state_d = RUN ? PH_HEX : IDLE;
                    if (rounds_q != 8'hff) rounds_d = rounds_q + 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end else if (tick) begin
            step_d = step_q + 1'b1;
        end
    end

    always_ff @(posedge CK) begin
        if (RS) begin
            state_q  <= IDLE;
            step_q   <= '0;
            rounds_q <= '0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            rounds_q <= rounds_d;
        end
    end

    assign SEL    = state_q;
    assign STEP   = step_q;
    assign TICK   = tick;
    assign DONE   = done;
    assign ROUNDS = rounds_q;

endmodule

// File: tb/tb_effect_scheduler.sv
// Directed bench for effect_scheduler with TICK_DIV=4, HEX=2, LEDG=3, LEDR=2 (28-cycle round).
module tb_effect_scheduler;

    logic       CK = 1'b0;
    logic       RS = 1'b1;
    logic       RUN = 1'b0;
    logic       HOLD = 1'b0;
    logic [1:0] SEL;
    logic [5:0] STEP;
    logic       TICK;
    logic       DONE;
    logic [7:0] ROUNDS;
    logic [17:0] obs;

    int n_checks = 0;
    int n_fail   = 0;

    effect_scheduler #(
        .TICK_DIV  (4),
        .HEX_TICKS (2),
        .LEDG_TICKS(3),
        .LEDR_TICKS(2)
    ) dut (
        .CK    (CK),
        .RS    (RS),
        .RUN   (RUN),
        .HOLD  (HOLD),
        .SEL   (SEL),
        .STEP  (STEP),
        .TICK  (TICK),
        .DONE  (DONE),
        .ROUNDS(ROUNDS)
    );

    always #5 CK = ~CK;

    assign obs = {SEL, STEP, TICK, DONE, ROUNDS};

    // Expected {SEL,STEP,TICK,DONE,ROUNDS} at cycle c (c>=1) of an uninterrupted run started at cycle 0.
    function automatic logic [17:0] exp_timeline(input int c);
        int r, o;
        logic [1:0] s;
        logic [5:0] st;
        logic t, d;
        r = (c - 1) / 28;
        o = (c - 1) % 28;
        if (o < 8) begin
            s = 2'd1; st = 6'(o / 4);
        end else if (o < 20) begin
            s = 2'd2; st = 6'((o - 8) / 4);
        end else begin
            s = 2'd3; st = 6'((o - 20) / 4);
        end
        t = (o % 4 == 3);
        d = t && (o == 7 || o == 19 || o == 27);
        return {s, st, t, d, 8'((r > 255) ? 255 : r)};
    endfunction

    task automatic step_cycle();
        @(posedge CK);
        #1;
    endtask

    // Leaves the bench in cycle 0: reset just released and RUN = 1.
    task automatic begin_run();
        RS = 1'b1; RUN = 1'b0; HOLD = 1'b0;
        step_cycle();
        RS = 1'b0; RUN = 1'b1;
    endtask

    task automatic test_reset();
        RS = 1'b1; RUN = 1'b1; HOLD = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step_cycle();
            n_checks++;
            if (obs !== 18'd0) begin
                n_fail++;
                $display("FAIL reset_outputs cycle=%0d got %h want 0", i, obs);
            end
        end
    endtask

    task automatic test_start();
        logic [1:0] e_sel;
        logic [5:0] e_step;
        logic e_tick, e_done;
        begin_run();
        n_checks++;
        if (obs !== 18'd0) begin
            n_fail++;
            $display("FAIL start_cycle0 got %h want 0", obs);
        end
        for (int c = 1; c <= 9; c++) begin
            step_cycle();
            e_sel  = (c <= 8) ? 2'd1 : 2'd2;
            e_step = (c >= 5 && c <= 8) ? 6'd1 : 6'd0;
            e_tick = (c == 4 || c == 8);
            e_done = (c == 8);
            n_checks++;
            if ({SEL, STEP, TICK, DONE} !== {e_sel, e_step, e_tick, e_done}) begin
                n_fail++;
                $display("FAIL start c=%0d got sel=%0d step=%0d tick=%b done=%b want sel=%0d step=%0d tick=%b done=%b",
                         c, SEL, STEP, TICK, DONE, e_sel, e_step, e_tick, e_done);
            end
        end
    endtask

    // Continues the run begun by test_start through the first LEDR->HEX wrap.
    task automatic test_full_round();
        for (int c = 10; c <= 36; c++) begin
            step_cycle();
            n_checks++;
            if (obs !== exp_timeline(c)) begin
                n_fail++;
                $display("FAIL full_round c=%0d got %h want %h", c, obs, exp_timeline(c));
            end
        end
    endtask

    task automatic test_stop();
        logic [17:0] e;
        begin_run();
        for (int c = 1; c <= 40; c++) begin
            step_cycle();
            e = (c <= 28) ? exp_timeline(c) : {2'd0, 6'd0, 1'b0, 1'b0, 8'd1};
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL stop c=%0d got %h want %h", c, obs, e);
            end
            if (c == 14) RUN = 1'b0;
        end
    endtask

    task automatic test_hold();
        logic [17:0] e;
        begin_run();
        for (int c = 1; c <= 3; c++) step_cycle();
        HOLD = 1'b1;
        for (int c = 4; c <= 20; c++) begin
            step_cycle();
            if (c == 13) HOLD = 1'b0;
            e = (c <= 13) ? exp_timeline(3) : exp_timeline(c - 10);
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL hold c=%0d got %h want %h", c, obs, e);
            end
        end
    endtask

    task automatic test_reset_mid();
        begin_run();
        for (int c = 1; c <= 19; c++) step_cycle();
        n_checks++;
        if (obs !== exp_timeline(19)) begin
            n_fail++;
            $display("FAIL reset_mid_pre got %h want %h", obs, exp_timeline(19));
        end
        RS = 1'b1;
        step_cycle();
        RS = 1'b0; RUN = 1'b0;
        n_checks++;
        if (obs !== 18'd0) begin
            n_fail++;
            $display("FAIL reset_mid_post got %h want 0", obs);
        end
        for (int c = 21; c <= 24; c++) begin
            step_cycle();
            n_checks++;
            if (obs !== 18'd0) begin
                n_fail++;
                $display("FAIL reset_mid_idle c=%0d got %h want 0", c, obs);
            end
        end
    endtask

    task automatic test_saturation();
        begin_run();
        for (int c = 1; c <= 7281; c++) begin
            step_cycle();
            if (c == 7113 || c == 7141 || c == 7281) begin
                n_checks++;
                if (obs !== exp_timeline(c)) begin
                    n_fail++;
                    $display("FAIL saturation c=%0d got %h want %h", c, obs, exp_timeline(c));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_full_round();
        test_stop();
        test_hold();
        test_reset_mid();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/effect_scheduler.md
EFFECT_SCHEDULER -- requirements
Module: effect_scheduler

Interface
REQ-001 SHALL provide parameter TICK_DIV, default 5000000, CK cycles per scheduler tick (100 ms at 50 MHz).
REQ-002 SHALL provide parameter HEX_TICKS, default 20, ticks in the HEX phase.
REQ-003 SHALL provide parameter LEDG_TICKS, default 32, ticks in the LEDG phase.
REQ-004 SHALL provide parameter LEDR_TICKS, default 16, ticks in the LEDR phase.
REQ-005 SHALL provide port CK  in  1  board clock; the block uses one clock, and every flop is on the rising edge of CK.
REQ-006 SHALL provide port RS  in  1  reset; synchronous, active-high.
REQ-007 SHALL provide port RUN  in  1  level; 1 = run and repeat the schedule, 0 = stop after the current round.
REQ-008 SHALL provide port HOLD  in  1  level; 1 = freeze the prescaler, step and state.
REQ-009 SHALL provide port SEL  out  2  active effect: 0 none, 1 HEX, 2 LEDG, 3 LEDR.
REQ-010 SHALL provide port STEP  out  6  tick index within the current phase.
REQ-011 SHALL provide port TICK  out  1  single-cycle tick pulse, used by effects as a clock enable.
REQ-012 SHALL provide port DONE  out  1  single-cycle pulse on the last tick of each phase.
REQ-013 SHALL provide port ROUNDS  out  8  count of completed HEX->LEDG->LEDR rounds.

Function
REQ-014 SHALL implement FSM states IDLE, PH_HEX, PH_LEDG, PH_LEDR, with SEL = 0/1/2/3 respectively.
REQ-015 IDLE SHALL go to PH_HEX on the cycle after RUN is sampled 1; on that entry, prescaler = 0 and STEP = 0.
REQ-016 The prescaler SHALL count 0..TICK_DIV-1 and wrap only outside IDLE with HOLD = 0; it holds at 0 in IDLE.
REQ-017 TICK SHALL be 1 exactly in cycles where prescaler == TICK_DIV-1 and HOLD = 0 and state != IDLE.
REQ-018 On TICK with STEP < N-1 (N = ticks of the current phase), STEP SHALL increment by 1.
REQ-019 On TICK with STEP == N-1, the block SHALL assert DONE in the same cycle, set STEP to 0 next cycle, and advance the state: PH_HEX->PH_LEDG, PH_LEDG->PH_LEDR, PH_LEDR->PH_HEX if RUN = 1, else IDLE.
REQ-020 ROUNDS SHALL increment on each DONE in PH_LEDR and saturate at 255.
REQ-021 RUN falling mid-round SHALL NOT abort the round; the remaining phases complete, then the state goes to IDLE.
REQ-022 HOLD = 1 SHALL freeze the prescaler, STEP, state and ROUNDS, and force TICK = 0 and DONE = 0; on release, counting resumes from the frozen value.
REQ-023 With RS = 1 and RUN = 1 in the same cycle, reset SHALL win.
REQ-024 A parameter value of 1 for any phase SHALL give a one-tick phase with DONE on its only tick.
REQ-025 All outputs SHALL be registered or decoded from registered state only; there are no combinational paths from RUN or HOLD to the outputs except TICK and DONE gating by HOLD.

Reset
REQ-026 On RS = 1 at a CK edge, the block SHALL set: state IDLE, SEL 0, STEP 0, prescaler 0, TICK 0, DONE 0, ROUNDS 0.
REQ-027 Reset asserted mid-phase SHALL take effect on the next edge with no DONE pulse.

Structure
REQ-028 Package effect_pkg SHALL hold the state enum, the SEL encodings (SEL_NONE, SEL_HEX, SEL_LEDG, SEL_LEDR) and the STEP width constant.
REQ-029 The prescaler SHALL be the sub-module tick_gen (inputs CK, RS, EN; output TICK); the FSM, STEP and ROUNDS logic stay in effect_scheduler.

Verification
(Params for all scenarios: TICK_DIV = 4, HEX_TICKS = 2, LEDG_TICKS = 3, LEDR_TICKS = 2.)
REQ-030 Start: RS released, RUN = 1 at cycle 0 -> SEL = 1 from cycle 1; TICK at cycles 4 and 8; DONE at 8; SEL = 2 at cycle 9.
REQ-031 Full round: RUN held at 1 -> SEL sequence 1,2,3,1; ROUNDS = 1 the cycle after the first PH_LEDR DONE; 28 cycles of TICK spacing verified.
REQ-032 Stop: RUN dropped during PH_LEDG STEP 1 -> LEDG and LEDR complete; SEL = 0 after the LEDR DONE; ROUNDS = 1; no further TICK.
REQ-033 Hold: HOLD = 1 for 10 cycles at prescaler = 2 -> no TICK during the hold; the next TICK comes 1 cycle after release; STEP is unchanged during the hold.
REQ-034 Reset mid-phase: RS pulsed in PH_LEDG STEP 2 -> next cycle all outputs are 0, with no DONE.
REQ-035 Saturation: 260 rounds with RUN = 1 -> ROUNDS stops at 255.
